// File: rtl/wallace_tree_accum_pkg.sv
// ---------------------------------------------------------------------------
// wallace_pkg
// Default sizing constants and elaboration-time helper functions for
// wallace_tree_accum. It sizes the output word, gives the reduction-depth
// hint, and supplies the vector counts per carry-save stage that the tree's
// generate loops use.
// ---------------------------------------------------------------------------
package wallace_pkg;

    localparam int DEF_N_INPUTS    = 4;
    localparam int DEF_WEIGHT_BITS = 3;
    localparam int DEF_INPUT_BITS  = 1;

    // floor(log2 n) + w + i + 1
    function automatic int calc_sum_bits(input int n, input int w, input int i);
        int lg;
        int v;
        lg = 0;
        v  = n;
        while (v > 1) begin
            v  = v / 2;
            lg = lg + 1;
        end
        return lg + w + i + 1;
    endfunction

    // 1 + ceil(log1.5(n*w/2)).  The loop finds the smallest k with
    // 1.5^k >= n*w/2, in the integer form 2*3^k >= n*w*2^k.
    function automatic int calc_h(input int n, input int w);
        longint lhs;
        longint rhs;
        int     k;
        lhs = 2;
        rhs = longint'(n * w);
        k   = 0;
        while (lhs < rhs) begin
            lhs = lhs * 3;
            rhs = rhs * 2;
            k   = k + 1;
        end
        return 1 + k;
    endfunction

    // Operand vectors left after s word-level 3:2 layers, starting from m.
    function automatic int stage_count(input int m, input int s);
        int n;
        n = m;
        for (int k = 0; k < s; k++) begin
            if (n > 2) n = 2 * (n / 3) + (n % 3);
        end
        return n;
    endfunction

    // Number of 3:2 layers needed to bring m vectors down to two.
    function automatic int csa_stages(input int m);
        int n;
        int s;
        n = m;
        s = 0;
        while (n > 2) begin
            n = 2 * (n / 3) + (n % 3);
            s = s + 1;
        end
        return s;
    endfunction

    localparam int DEF_SUM_BITS = calc_sum_bits(DEF_N_INPUTS, DEF_WEIGHT_BITS, DEF_INPUT_BITS);
    localparam int DEF_H        = calc_h(DEF_N_INPUTS, DEF_WEIGHT_BITS);

endpackage

// File: rtl/wallace_tree_accum_if.sv
// ---------------------------------------------------------------------------
// wallace_tree_accum_if
// Operand and result bundle between the partial-product generator (master)
// and the accumulator (slave).
//   multiplicants : packed partial-product rows, row r at [r*WEIGHT_BITS +: WEIGHT_BITS]
//   bias          : neuron bias, weight 2^0
//   baugh_wooley  : sign-correction constant, weight 2^INPUT_BITS
//   sum           : registered total, modulo 2^SUM_BITS
// ---------------------------------------------------------------------------
interface wallace_tree_accum_if
    import wallace_pkg::*;
#(
    parameter int N_INPUTS    = DEF_N_INPUTS,
    parameter int WEIGHT_BITS = DEF_WEIGHT_BITS,
    parameter int INPUT_BITS  = DEF_INPUT_BITS,
    parameter int SUM_BITS    = calc_sum_bits(N_INPUTS, WEIGHT_BITS, INPUT_BITS)
);

    logic [N_INPUTS*INPUT_BITS*WEIGHT_BITS-1:0] multiplicants;
    logic [WEIGHT_BITS-1:0]                     bias;
    logic [SUM_BITS-INPUT_BITS-1:0]             baugh_wooley;
    logic [SUM_BITS-1:0]                        sum;

    modport master (
        output multiplicants,
        output bias,
        output baugh_wooley,
        input  sum
    );

    modport slave (
        input  multiplicants,
        input  bias,
        input  baugh_wooley,
        output sum
    );

endinterface

// File: rtl/wallace_tree_accum_csa_3to2.sv
// ---------------------------------------------------------------------------
// csa_3to2
// One carry-save layer: a row of WIDTH full adders that turns three aligned
// vectors into a sum vector and a carry vector.
//   i_a, i_b, i_c : addends
//   o_sum         : bitwise XOR of the three addends
//   o_carry       : majority shifted up one column; the carry out of the top
//                   column is discarded because the result is modulo 2^WIDTH
// ---------------------------------------------------------------------------
module csa_3to2 #(
    parameter int WIDTH = 7
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    output logic [WIDTH-1:0] o_sum,
    output logic [WIDTH-1:0] o_carry
);

    logic [WIDTH-2:0] w_maj;

    assign o_sum   = i_a ^ i_b ^ i_c;
    assign w_maj   = (i_a[WIDTH-2:0] & i_b[WIDTH-2:0])
                   | (i_a[WIDTH-2:0] & i_c[WIDTH-2:0])
                   | (i_b[WIDTH-2:0] & i_c[WIDTH-2:0]);
    assign o_carry = {w_maj, 1'b0};

endmodule

// File: rtl/wallace_tree_accum.sv
// ---------------------------------------------------------------------------
// wallace_tree_accum
// Registered Wallace-tree adder for one neuron. It sums N_INPUTS*INPUT_BITS
// partial-product rows, the bias and the Baugh-Wooley constant. The operands
// pass through layered 3:2 carry-save reduction, then one carry-propagate
// adder, then the output register.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears all registers
//   bus   : wallace_tree_accum_if.slave (operands in, sum out)
// Optional build macro WALLACE_TREE_PIPE_EN: adds a register stage on the
// carry-save pair (S, C) ahead of the final adder, so latency becomes 2.
// ---------------------------------------------------------------------------
module wallace_tree_accum
    import wallace_pkg::*;
#(
    parameter int N_INPUTS    = DEF_N_INPUTS,
    parameter int WEIGHT_BITS = DEF_WEIGHT_BITS,
    parameter int INPUT_BITS  = DEF_INPUT_BITS,
    parameter int SUM_BITS    = calc_sum_bits(N_INPUTS, WEIGHT_BITS, INPUT_BITS)
) (
    input logic                 clk,
    input logic                 rst_n,
    wallace_tree_accum_if.slave bus
);

    localparam int ROWS   = N_INPUTS * INPUT_BITS;
    localparam int M      = ROWS + 2;
    localparam int STAGES = csa_stages(M);

    // w_vec[s][k]: operand vector k entering reduction layer s. Slots beyond
    // the live count of a layer are tied to zero, so every slot has exactly one
    // driver.
    logic [SUM_BITS-1:0] w_vec [0:STAGES][0:M-1];
    logic [SUM_BITS-1:0] w_s;
    logic [SUM_BITS-1:0] w_c;
    logic [SUM_BITS-1:0] w_cpa;
    logic [SUM_BITS-1:0] r_sum;

    // Row r belongs to input bit j = r % INPUT_BITS and carries weight 2^j.
    for (genvar r = 0; r < ROWS; r++) begin : g_rows
        assign w_vec[0][r] =
            SUM_BITS'(bus.multiplicants[r*WEIGHT_BITS +: WEIGHT_BITS]) << (r % INPUT_BITS);
    end
    assign w_vec[0][ROWS]   = SUM_BITS'(bus.bias);
    assign w_vec[0][ROWS+1] = {bus.baugh_wooley, {INPUT_BITS{1'b0}}};

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int CNT = stage_count(M, s);
        localparam int G   = CNT / 3;
        localparam int REM = CNT % 3;

        for (genvar g = 0; g < G; g++) begin : g_csa
            csa_3to2 #(
                .WIDTH (SUM_BITS)
            ) u_csa (
                .i_a     (w_vec[s][3*g]),
                .i_b     (w_vec[s][3*g+1]),
                .i_c     (w_vec[s][3*g+2]),
                .o_sum   (w_vec[s+1][2*g]),
                .o_carry (w_vec[s+1][2*g+1])
            );
        end

        // Leftover vectors (fewer than three) skip this layer unchanged.
        for (genvar d = 2*G; d < M; d++) begin : g_fwd
            if (d < 2*G + REM) begin : g_pass
                assign w_vec[s+1][d] = w_vec[s][3*G + d - 2*G];
            end else begin : g_zero
                assign w_vec[s+1][d] = '0;
            end
        end
    end

    assign w_s = w_vec[STAGES][0];
    assign w_c = w_vec[STAGES][1];

`ifdef WALLACE_TREE_PIPE_EN
    logic [SUM_BITS-1:0] r_s;
    logic [SUM_BITS-1:0] r_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s <= '0;
            r_c <= '0;
        end else begin
            r_s <= w_s;
            r_c <= w_c;
        end
    end

    assign w_cpa = r_s + r_c;
`else
    assign w_cpa = w_s + w_c;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else begin
            r_sum <= w_cpa;
        end
    end

    assign bus.sum = r_sum;

endmodule

// File: tb/tb_wallace_tree_accum.sv
// ---------------------------------------------------------------------------
// tb_wallace_tree_accum
// Scoreboard bench. The driver applies operands on the falling edge and
// queues the arithmetic expectation with the cycle it is due. The monitor
// compares sum against every expectation that has come due, just after each
// rising edge.
// ---------------------------------------------------------------------------
module tb_wallace_tree_accum;
    import wallace_pkg::*;

    localparam int N  = DEF_N_INPUTS;
    localparam int W  = DEF_WEIGHT_BITS;
    localparam int I  = DEF_INPUT_BITS;
    localparam int SB = DEF_SUM_BITS;
    localparam int MW = N * I * W;
`ifdef WALLACE_TREE_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wallace_tree_accum_if #(
        .N_INPUTS (N), .WEIGHT_BITS (W), .INPUT_BITS (I), .SUM_BITS (SB)
    ) bus ();

    wallace_tree_accum #(
        .N_INPUTS (N), .WEIGHT_BITS (W), .INPUT_BITS (I), .SUM_BITS (SB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int    exp;
        int    due;
        string name;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Plain weighted sum: each row times 2^(input bit), plus bias, plus
    // correction constant times 2^INPUT_BITS, reduced modulo 2^SB.
    function automatic int model(input logic [MW-1:0] m, input logic [W-1:0] b,
                                 input logic [SB-I-1:0] bw);
        int acc;
        acc = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < I; j++)
                acc += int'(m[(i*I+j)*W +: W]) * (1 << j);
        acc += int'(b) + int'(bw) * (1 << I);
        return acc % (1 << SB);
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic issue(input logic [MW-1:0] m, input logic [W-1:0] b,
                         input logic [SB-I-1:0] bw, input string nm);
        exp_t e;
        bus.multiplicants = m;
        bus.bias          = b;
        bus.baugh_wooley  = bw;
        e.exp  = model(m, b, bw);
        e.due  = cyc + LAT;
        e.name = nm;
        q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            while (q.size() > 0 && q[0].due <= cyc) begin
                exp_t e;
                e = q.pop_front();
                check(e.name, int'(bus.sum), e.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [MW-1:0]   m;
        logic [W-1:0]    b;
        logic [SB-I-1:0] bw;

        rst_n             = 1'b0;
        bus.multiplicants = MW'(12'hABC);
        bus.bias          = W'(5);
        bus.baugh_wooley  = (SB-I)'(9);
        #3;
        check("reset_async", int'(bus.sum), 0);
        repeat (2) @(negedge clk);
        check("reset_hold", int'(bus.sum), 0);
        rst_n = 1'b1;
        issue(MW'(12'hABC), W'(5), (SB-I)'(9), "after_reset");

        @(negedge clk); issue(MW'(12'hFFF), W'(7), (SB-I)'(0),  "max_rows");
        @(negedge clk); issue(MW'(12'hFFF), W'(7), (SB-I)'(63), "wrap");
        @(negedge clk); issue(MW'(12'h431), W'(7), (SB-I)'(11), "mixed");
        @(negedge clk); issue(MW'(12'h000), W'(0), (SB-I)'(0),  "zero");
        @(negedge clk); issue(MW'(12'h008), W'(0), (SB-I)'(0),  "single_bit");
        repeat (LAT + 1) @(negedge clk);
        check("directed_drained", q.size(), 0);

        // Directed spot checks on the hand-derived values.
        check("model_max_rows", model(MW'(12'hFFF), W'(7), (SB-I)'(0)), 35);
        check("model_wrap", model(MW'(12'hFFF), W'(7), (SB-I)'(63)), 33);
        check("model_mixed", model(MW'(12'h431), W'(7), (SB-I)'(11)), 38);

        // Random operands, then reset asserted between edges.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            issue(MW'($urandom), W'($urandom), (SB-I)'($urandom), "random");
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_midcycle", int'(bus.sum), 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        m  = '0;
        b  = '0;
        bw = '0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (k == 500) begin
                #1;
                rst_n = 1'b0;
                #1;
                check("reset_stream", int'(bus.sum), 0);
                q.delete();
                rst_n = 1'b1;
            end
            issue(m, b, bw, "stream");
            m  = MW'(int'(m) + 520369201);
            b  = W'(int'(b) + 7);
            bw = (SB-I)'(int'(bw) + 11);
        end

        repeat (LAT + 3) @(negedge clk);
        check("stream_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
